// File: rtl/display_bcd_mux.sv
// display_bcd_mux
//   Scans three latched BCD digits (hundreds/tens/units) onto a shared
//   common-anode seven-segment bus, one digit at a time. The dwell per digit
//   comes from an internal prescaler. Codes 10..15 are shown as a dash.
//
//   Compile-time option: DISPLAY_BLANK_ZEROS_EN
//     defined   -> leading zeros on hundreds/tens are blanked (units never)
//     undefined -> every digit is always decoded
//
// Ports
//   clock      in   1  sole clock, rising edge
//   reset      in   1  asynchronous, active-high reset
//   carregar   in   1  load strobe, digits sampled on every edge it is high
//   centenas   in   4  hundreds BCD digit
//   dezenas    in   4  tens BCD digit
//   unitarios  in   4  units BCD digit
//   apagar     in   1  forces the display dark while high (scan keeps running)
//   anodos     out  3  one-hot active-low anodes: bit0 units, bit1 tens, bit2 hundreds
//   segmentos  out  7  active-low segments, bit6..bit0 = g,f,e,d,c,b,a
module display_bcd_mux #(
    parameter int DIV_SCAN = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       carregar,
    input  logic [3:0] centenas,
    input  logic [3:0] dezenas,
    input  logic [3:0] unitarios,
    input  logic       apagar,
    output logic [2:0] anodos,
    output logic [6:0] segmentos
);

    localparam int PRE_W = (DIV_SCAN > 1) ? $clog2(DIV_SCAN) : 1;

    localparam logic [1:0] DIG_U = 2'd0;
    localparam logic [1:0] DIG_D = 2'd1;
    localparam logic [1:0] DIG_C = 2'd2;

    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [2:0] AN_OFF   = 3'b111;

    logic [3:0]       c_r, d_r, u_r;
    logic [PRE_W-1:0] pre;
    logic             tick;
    logic [1:0]       idx, idx_nxt;
    logic [3:0]       sel;
    logic             blank_sel;
    logic             blank_c, blank_d;
    logic [2:0]       an_d;
    logic [6:0]       seg_d;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = SEG_DASH;
        endcase
    endfunction

    // Digit latches
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            c_r <= '0;
            d_r <= '0;
            u_r <= '0;
        end else if (carregar) begin
            c_r <= centenas;
            d_r <= dezenas;
            u_r <= unitarios;
        end
    end

    // Prescaler: one tick every DIV_SCAN cycles
    assign tick = (pre == PRE_W'(DIV_SCAN - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset)     pre <= '0;
        else if (tick) pre <= '0;
        else           pre <= pre + 1'b1;
    end

    // Scan FSM: state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) idx <= DIG_U;
        else       idx <= idx_nxt;
    end

    // Scan FSM: next state (index 3 is never entered, but recovers to units)
    always_comb begin
        idx_nxt = idx;
        case (idx)
            DIG_U:   if (tick) idx_nxt = DIG_D;
            DIG_D:   if (tick) idx_nxt = DIG_C;
            DIG_C:   if (tick) idx_nxt = DIG_U;
            default: idx_nxt = DIG_U;
        endcase
    end

`ifdef DISPLAY_BLANK_ZEROS_EN
    // Tens is only a leading zero when hundreds is zero as well
    assign blank_c = (c_r == 4'd0);
    assign blank_d = (c_r == 4'd0) && (d_r == 4'd0);
`else
    assign blank_c = 1'b0;
    assign blank_d = 1'b0;
`endif

    // Scan FSM: outputs (registered below, so anodes lag idx by one edge)
    always_comb begin
        sel       = u_r;
        blank_sel = 1'b0;
        an_d      = AN_OFF;
        case (idx)
            DIG_U: begin sel = u_r; blank_sel = 1'b0;    an_d = 3'b110; end
            DIG_D: begin sel = d_r; blank_sel = blank_d; an_d = 3'b101; end
            DIG_C: begin sel = c_r; blank_sel = blank_c; an_d = 3'b011; end
            default: begin sel = u_r; blank_sel = 1'b1;  an_d = AN_OFF; end
        endcase
        seg_d = blank_sel ? SEG_OFF : decode(sel);
        if (apagar) begin
            an_d  = AN_OFF;
            seg_d = SEG_OFF;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            anodos    <= AN_OFF;
            segmentos <= SEG_OFF;
        end else begin
            anodos    <= an_d;
            segmentos <= seg_d;
        end
    end

endmodule

// File: tb/tb_display_bcd_mux.sv
module tb_display_bcd_mux;

    localparam int D = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       carregar = 1'b0;
    logic       apagar = 1'b0;
    logic [3:0] centenas = 4'd0;
    logic [3:0] dezenas = 4'd0;
    logic [3:0] unitarios = 4'd0;
    logic [2:0] anodos;
    logic [6:0] segmentos;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    display_bcd_mux #(.DIV_SCAN(D)) dut (
        .clock    (clock),
        .reset    (reset),
        .carregar (carregar),
        .centenas (centenas),
        .dezenas  (dezenas),
        .unitarios(unitarios),
        .apagar   (apagar),
        .anodos   (anodos),
        .segmentos(segmentos)
    );

    // ---------------- reference model ----------------
    // k counts edges since reset release; output at edge k shows digit
    // (k / D) % 3 from the digit values held before that edge.
    int         k;
    logic [3:0] m_u, m_d, m_c;
    logic [2:0] exp_an;
    logic [6:0] exp_seg;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic logic [6:0] model_seg(input int dig, input logic [3:0] u,
                                             input logic [3:0] d, input logic [3:0] c);
        logic hide_c, hide_d;
`ifdef DISPLAY_BLANK_ZEROS_EN
        hide_c = (c == 4'd0);
        hide_d = (c == 4'd0) && (d == 4'd0);
`else
        hide_c = 1'b0;
        hide_d = 1'b0;
`endif
        if (dig == 0) return glyph(u);
        if (dig == 1) return hide_d ? 7'h7F : glyph(d);
        return hide_c ? 7'h7F : glyph(c);
    endfunction

    function automatic logic [2:0] model_an(input int dig);
        logic [2:0] one;
        one = 3'b001 << dig;
        return ~one;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            k       <= 0;
            m_u     <= 4'd0;
            m_d     <= 4'd0;
            m_c     <= 4'd0;
            exp_an  <= 3'b111;
            exp_seg <= 7'h7F;
        end else begin
            exp_an  <= apagar ? 3'b111 : model_an((k / D) % 3);
            exp_seg <= apagar ? 7'h7F : model_seg((k / D) % 3, m_u, m_d, m_c);
            if (carregar) begin
                m_u <= unitarios;
                m_d <= dezenas;
                m_c <= centenas;
            end
            k <= k + 1;
        end
    end

    // ---------------- tests (each called at a falling edge) ----------------
    task automatic test_reset();
        @(posedge clock); #1;
        n_chk++;
        if (anodos !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_anodos got=%b want=111", anodos);
        end
        n_chk++;
        if (segmentos !== 7'h7F) begin
            n_fail++;
            $display("FAIL reset_segmentos got=%b want=1111111", segmentos);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_scan();
        for (int i = 0; i < 24; i++) begin
            @(posedge clock); #1;
            if (i == 0) begin
                n_chk++;
                if (anodos !== 3'b110 || segmentos !== 7'b1000000) begin
                    n_fail++;
                    $display("FAIL scan_first_edge got=%b/%b want=110/1000000", anodos, segmentos);
                end
            end
            n_chk++;
            if (anodos !== exp_an) begin
                n_fail++;
                $display("FAIL scan cyc=%0d anodos got=%b want=%b", i, anodos, exp_an);
            end
            n_chk++;
            if ($countones(~anodos) != 1) begin
                n_fail++;
                $display("FAIL scan_onehot cyc=%0d anodos got=%b want one active", i, anodos);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_load(input string name, input logic [3:0] c,
                             input logic [3:0] d, input logic [3:0] u);
        centenas = c; dezenas = d; unitarios = u; carregar = 1'b1;
        for (int i = 0; i < 3 * D + 2; i++) begin
            @(posedge clock); #1;
            n_chk++;
            if (anodos !== exp_an || segmentos !== exp_seg) begin
                n_fail++;
                $display("FAIL %s cyc=%0d got=%b/%b want=%b/%b",
                         name, i, anodos, segmentos, exp_an, exp_seg);
            end
            @(negedge clock);
            carregar  = 1'b0;
            centenas  = 4'(($urandom_range(0, 15)));
            dezenas   = 4'(($urandom_range(0, 15)));
            unitarios = 4'(($urandom_range(0, 15)));
        end
    endtask

    task automatic test_blank();
        for (int i = 0; i < 20; i++) begin
            apagar = (i >= 5 && i < 11);
            @(posedge clock); #1;
            n_chk++;
            if (anodos !== exp_an || segmentos !== exp_seg) begin
                n_fail++;
                $display("FAIL blank cyc=%0d got=%b/%b want=%b/%b",
                         i, anodos, segmentos, exp_an, exp_seg);
            end
            if (i >= 5 && i < 11) begin
                n_chk++;
                if (anodos !== 3'b111) begin
                    n_fail++;
                    $display("FAIL blank_off cyc=%0d anodos got=%b want=111", i, anodos);
                end
            end
            @(negedge clock);
        end
        apagar = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            carregar  = ($urandom_range(0, 3) == 0);
            apagar    = ($urandom_range(0, 7) == 0);
            centenas  = 4'(($urandom_range(0, 15)));
            dezenas   = 4'(($urandom_range(0, 15)));
            unitarios = 4'(($urandom_range(0, 15)));
            @(posedge clock); #1;
            n_chk++;
            if (anodos !== exp_an || segmentos !== exp_seg) begin
                n_fail++;
                $display("FAIL random cyc=%0d got=%b/%b want=%b/%b",
                         i, anodos, segmentos, exp_an, exp_seg);
            end
            @(negedge clock);
        end
        carregar = 1'b0;
        apagar   = 1'b0;
    endtask

    task automatic test_reset_mid();
        centenas = 4'd9; dezenas = 4'd9; unitarios = 4'd9; carregar = 1'b1;
        @(posedge clock);
        @(negedge clock);
        carregar = 1'b0;
        repeat (5) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        n_chk++;
        if (anodos !== 3'b111 || segmentos !== 7'h7F) begin
            n_fail++;
            $display("FAIL reset_mid got=%b/%b want=111/1111111", anodos, segmentos);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3 * D; i++) begin
            @(posedge clock); #1;
            if (i == 0) begin
                n_chk++;
                if (anodos !== 3'b110 || segmentos !== 7'b1000000) begin
                    n_fail++;
                    $display("FAIL reset_mid_units got=%b/%b want=110/1000000", anodos, segmentos);
                end
            end
            n_chk++;
            if (anodos !== exp_an || segmentos !== exp_seg) begin
                n_fail++;
                $display("FAIL reset_mid_after cyc=%0d got=%b/%b want=%b/%b",
                         i, anodos, segmentos, exp_an, exp_seg);
            end
            @(negedge clock);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load("normal_255", 4'd2, 4'd5, 4'd5);
        test_load("leading_zeros", 4'd0, 4'd0, 4'd7);
        test_load("tens_zero_only", 4'd3, 4'd0, 4'd1);
        test_load("invalid_tens", 4'd1, 4'hC, 4'd8);
        test_blank();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/display_bcd_mux.md
# display_bcd_mux

Time-multiplexed driver for a 3-digit common-anode seven-segment display, sitting directly downstream of the byte-to-BCD converter. It latches the hundreds, tens and units BCD digits on a load strobe and scans them onto shared segment lines, one digit at a time. Scan rate comes from an internal prescaler. Invalid BCD codes are shown as a dash, and leading-zero blanking is a compile-time option.

## Interface
- `DIV_SCAN`, default 50000: clock cycles each digit stays active; legal range ≥ 2.
- `clock`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `carregar`  in  1  load strobe; inputs are sampled on every rising edge where it is high.
- `centenas`  in  4  hundreds BCD digit.
- `dezenas`  in  4  tens BCD digit.
- `unitarios`  in  4  units BCD digit.
- `apagar`  in  1  display blank; forces all anodes off while high.
- `anodos`  out  3  one-hot, active-low digit enable; bit0 = units, bit1 = tens, bit2 = hundreds.
- `segmentos`  out  7  active-low segments, bit order g,f,e,d,c,b,a (bit6 = g).

## Operation
- **Latch registers `c_r`, `d_r`, `u_r` (4 bits each).**
  - Loaded from the inputs on any edge where `carregar`=1.
  - Otherwise they hold.
  - `carregar` held high reloads on every edge.
- **Prescaler `pre`.**
  - Counts 0 .. DIV_SCAN-1, then wraps to 0.
  - `tick` = (`pre` == DIV_SCAN-1).
  - Width is clog2(DIV_SCAN).
- **Digit index `idx` (2 bits), 3-state scan FSM.**
  - Sequence: DIG_U(0) → DIG_D(1) → DIG_C(2) → DIG_U.
  - Advances only on `tick`.
  - Value 3 is unreachable; if it is ever reached, the next edge forces it to 0.
- **Digit select.** `sel` = `u_r` / `d_r` / `c_r` for `idx` = 0 / 1 / 2.
- **Decode, active low, g..a.**
  - 0 = 1000000
  - 1 = 1111001
  - 2 = 0100100
  - 3 = 0110000
  - 4 = 0011001
  - 5 = 0010010
  - 6 = 0000010
  - 7 = 1111000
  - 8 = 0000000
  - 9 = 0010000
  - 10–15 = 0111111 (dash)
- **Output registers.** Every edge:
  - `anodos` = ~(1 << `idx`), or 111 if `apagar`=1.
  - `segmentos` = decode(`sel`) after the blanking rule, or 1111111 if `apagar`=1.
- **`apagar`.** Does not stop the prescaler or the FSM; the scan phase is preserved.
- **Simultaneous `carregar` and `tick`.** Both take effect; the next output uses the new latch values and the new index.

## Timing
- **Reset values.**
  - `anodos` = 111
  - `segmentos` = 1111111
  - `pre` = 0
  - `idx` = 0
  - `c_r`, `d_r`, `u_r` = 0
- **Reset is asynchronous.** Outputs go to their reset values immediately on assertion, including mid-scan.
- **First edge after reset release.** `anodos` = 110, `segmentos` = 1000000.
- **Load to display latency.** `carregar` sampled at edge N → the latched value appears on `segmentos` at edge N+1 whenever that digit is active.
- **Index to output latency.** One-cycle registered pipeline. `idx` changes at the edge where `tick`=1; `anodos` follows at the next edge.
- **Dwell.** Each digit's anode is active for exactly DIV_SCAN cycles. The full frame is 3·DIV_SCAN cycles.
- **`apagar` latency.** Takes effect at the first edge after assertion; release restores the current scan digit at the next edge.

## Configuration
- **Macro `DISPLAY_BLANK_ZEROS_EN`.**
- **Defined (leading-zero blanking on):**
  - Hundreds shows 1111111 when `c_r`=0.
  - Tens shows 1111111 when `c_r`=0 and `d_r`=0.
  - Units is never blanked.
  - Anode timing is unchanged; a blanked digit still gets its anode slot.
- **Undefined:** all three digits are always decoded, including leading zeros.

## Test plan
- **Scan sequence.** DIV_SCAN=4, reset, then run 24 cycles → `anodos` holds 110 for 4 cycles, then 101 for 4, then 011 for 4, then repeats 110; no cycle with two anodes active.
- **Normal value.** Load 2,5,5 → units and tens slots show 0010010; hundreds slot shows 0100100; the value appears one edge after the `carregar` edge.
- **Leading zeros.** Load 0,0,7.
  - With the macro: hundreds and tens = 1111111, units = 1111000.
  - Without the macro: hundreds and tens = 1000000.
- **Invalid code.** Load `dezenas`=4'hC → tens slot = 0111111; the other digits are decoded normally.
- **Blank input.** Assert `apagar` for 6 cycles mid-frame → `anodos` = 111 from the next edge. On release, the scan resumes at the phase it would have reached without blanking.
- **Reset mid-scan.** Assert `reset` mid-scan with latches at 9,9,9 → outputs 111 / 1111111 immediately. After release: units slot shows 1000000 (latches cleared), with `idx` = 0.
